pool_window_gen: RTL and testbench
==================================

# pool_window_gen

Raster-to-window front end for the 2x2/stride-2 max-pooling stage. Accepts a row-major pixel stream for one feature map, buffers one even row, and emits each non-overlapping 2x2 window as four parallel pixels with a valid/ready handshake. It sits directly upstream of the pooling compare unit and drives its four pixel inputs.

## Interface
- `N`, 16: pixel bit width.
- `IMG_W`, 32: feature-map width in pixels; must be even, ≥2.
- `IMG_H`, 32: feature-map height in pixels; must be even, ≥2.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `in_data` holds a pixel.
- `in_data`  in  N  pixel, raster order (row 0 col 0 first).
- `in_ready`  out  1  block accepts `in_data` this cycle.
- `win_valid`  out  1  window outputs hold a complete window.
- `win_ready`  in  1  downstream consumes window this cycle.
- `win_tl`, `win_tr`, `win_bl`, `win_br`  out  N each  top-left, top-right, bottom-left, bottom-right pixels; these map to the pooling unit's `input1`..`input4`.
- `win_last`  out  1  qualifies the final window of the frame (row IMG_H-2, col IMG_W-2).

## Operation
- Transfer on input when `in_valid && in_ready`; on output when `win_valid && win_ready`.
- Counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1), width `$clog2` of each dimension; advance on each input transfer; `col` wraps to 0 and increments `row`; at (IMG_H-1, IMG_W-1) both wrap to 0 (next frame starts immediately, no gap required).
- Even row: store pixel in line buffer at index `col` (IMG_W x N registers).
- Odd row, even col: hold pixel in `bl_hold` register.
- Odd row, odd col: load output register: `win_tl`=buf[col-1], `win_tr`=buf[col], `win_bl`=`bl_hold`, `win_br`=`in_data`; set `win_valid`; `win_last` = (row==IMG_H-1 && col==IMG_W-1).
- Output register is a single entry. `win_valid` clears on output transfer unless a new window is loaded the same cycle (load wins, stays 1).
- `in_ready` = !`win_valid` || `win_ready` (registered-state based, combinational on `win_ready`). Stalling applies to all pixels, not only completing ones, so counters never run ahead of an unconsumed window.
- Window outputs hold stable while `win_valid && !win_ready`.
- Pixels are treated as opaque N-bit values; no arithmetic on data.

## Timing
- Reset (async assert, sync-safe release): `col`=0, `row`=0, `win_valid`=0, `win_last`=0, `win_tl/tr/bl/br`=0, `bl_hold`=0; line buffer need not reset. `in_ready`=1 after reset.
- Latency: window appears (`win_valid`=1) the cycle after the bottom-right pixel transfer.
- Throughput: one pixel per cycle sustained with `win_ready` held 1; one window per 2 cycles during odd rows, none during even rows.
- Back-pressure: with `win_valid`=1 and `win_ready`=0, `in_ready`=0; no pixel lost or duplicated.
- Simultaneous output transfer and completing input transfer: old window consumed, new window loaded, `win_valid` stays 1.
- Reset mid-frame: partial frame discarded; next accepted pixel is row 0 col 0; pending window dropped.
- `in_valid` low: counters hold, no state change except output drain.

## Test plan
- IMG_W=4, IMG_H=4, N=16, `win_ready`=1, pixels 0..15 back-to-back -> 4 windows {0,1,4,5}, {2,3,6,7}, {8,9,12,13}, {10,11,14,15}, each 1 cycle after its br pixel; `win_last` only on the fourth.
- Same stream, `win_ready`=0 for 5 cycles after first window -> `in_ready`=0, window {0,1,4,5} held stable, then stream resumes with identical remaining windows.
- Two frames back-to-back (pixels 0..15 then 100..115) -> second frame windows start {100,101,104,105}; no cross-frame mixing.
- Random `in_valid` gaps (~50%) and random `win_ready` -> window sequence equals reference model; no drops/duplicates; `in_ready` never 1 while output held and not consumed.
- Assert `rst_n`=0 after pixel 6 of frame, release, send 0..15 -> all outputs 0 during reset, then the 4 correct windows of a fresh frame.
- Max-value pixels 16'hFFFF and 0 alternating -> exact bit-preserving pass-through to window ports.

Source files
------------

// File: rtl/pool_window_gen_if.sv
// pool_window_gen_if: pixel-in and 2x2-window-out handshake bundle
interface pool_window_gen_if #(parameter int N = 16);
  logic         in_valid;
  logic [N-1:0] in_data;
  logic         in_ready;
  logic         win_valid;
  logic         win_ready;
  logic [N-1:0] win_tl;
  logic [N-1:0] win_tr;
  logic [N-1:0] win_bl;
  logic [N-1:0] win_br;
  logic         win_last;
  modport master (
    output in_valid, in_data, win_ready,
    input  in_ready, win_valid, win_tl, win_tr, win_bl, win_br, win_last
  );
  modport slave (
    input  in_valid, in_data, win_ready,
    output in_ready, win_valid, win_tl, win_tr, win_bl, win_br, win_last
  );
endinterface

// File: rtl/pool_window_gen.sv
// pool_window_gen: raster pixel stream to non-overlapping 2x2 windows
module pool_window_gen #(
  parameter int N     = 16,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32
) (
  input logic              clk,
  input logic              rst_n,
  pool_window_gen_if.slave bus
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [N-1:0]  line_buf [IMG_W];
  logic [N-1:0]  bl_hold;
  logic          xfer_in, load, col_last, row_last;
  logic [CW-1:0] col_left;
  // a pixel may enter only when the single output slot is free or draining
  assign bus.in_ready = !bus.win_valid || bus.win_ready;
  assign xfer_in      = bus.in_valid && bus.in_ready;
  assign col_last     = col == CW'(IMG_W - 1);
  assign row_last     = row == RW'(IMG_H - 1);
  assign load         = xfer_in && row[0] && col[0];
  assign col_left     = {col[CW-1:1], 1'b0};
  // even rows fill the line buffer; contents need no reset
  always_ff @(posedge clk)
    if (xfer_in && !row[0]) line_buf[col] <= bus.in_data;
  // raster counters, bottom-left hold and the single-entry window register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col           <= '0;
      row           <= '0;
      bl_hold       <= '0;
      bus.win_valid <= 1'b0;
      bus.win_last  <= 1'b0;
      bus.win_tl    <= '0;
      bus.win_tr    <= '0;
      bus.win_bl    <= '0;
      bus.win_br    <= '0;
    end else begin
      if (xfer_in) begin
        col <= col_last ? '0 : col + 1'b1;
        if (col_last) row <= row_last ? '0 : row + 1'b1;
      end
      if (xfer_in && row[0] && !col[0]) bl_hold <= bus.in_data;
      if (load) begin
        bus.win_tl    <= line_buf[col_left];
        bus.win_tr    <= line_buf[col];
        bus.win_bl    <= bl_hold;
        bus.win_br    <= bus.in_data;
        bus.win_last  <= row_last && col_last;
        bus.win_valid <= 1'b1;
      end else if (bus.win_ready) begin
        bus.win_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pool_window_gen.sv
// tb_pool_window_gen: scoreboard bench for the 2x2 window generator on a 4x4 map
module tb_pool_window_gen;
  localparam int W = 4, H = 4, N = 16;
  typedef struct packed {
    logic [N-1:0] tl, tr, bl, br;
    logic         last;
  } win_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  pool_window_gen_if #(.N(N)) bus ();
  pool_window_gen #(.N(N), .IMG_W(W), .IMG_H(H)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  win_t q[$];
  int   vectors = 0, fails = 0;
  bit   rdy_rand = 0, gaps = 0, stall_arm = 0;
  int   stall_left = 0;
  // monitor: samples mid-low-phase, after the driver has settled the inputs
  int   pos = 0;
  bit   due = 0, held = 0;
  win_t cur, prev, exp_w;
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      pos = 0; due = 0; held = 0;
    end else begin
      cur = {bus.win_tl, bus.win_tr, bus.win_bl, bus.win_br, bus.win_last};
      if (due) begin
        vectors++;
        if (!bus.win_valid) begin fails++; $display("FAIL latency: win_valid=%0b required 1 (pixel %0d)", bus.win_valid, pos - 1); end
      end
      if (held) begin
        vectors++;
        if (cur != prev) begin fails++; $display("FAIL hold: window %h changed, required %h", cur, prev); end
      end
      if (bus.win_valid && !bus.win_ready) begin
        vectors++;
        if (bus.in_ready) begin fails++; $display("FAIL backpressure: in_ready=%0b required 0", bus.in_ready); end
      end
      if (bus.win_valid && bus.win_ready) begin
        vectors++;
        if (q.size() == 0) begin
          fails++; $display("FAIL extra_window: got %h, none expected", cur);
        end else begin
          exp_w = q.pop_front();
          if (cur != exp_w) begin fails++; $display("FAIL window: got tl=%h tr=%h bl=%h br=%h last=%0b required tl=%h tr=%h bl=%h br=%h last=%0b", cur.tl, cur.tr, cur.bl, cur.br, cur.last, exp_w.tl, exp_w.tr, exp_w.bl, exp_w.br, exp_w.last); end
        end
      end
      held = bus.win_valid && !bus.win_ready;
      prev = cur;
      due = 0;
      if (bus.in_valid && bus.in_ready) begin
        due = ((pos / W) % 2 == 1) && ((pos % W) % 2 == 1);
        pos = (pos + 1) % (W * H);
      end
    end
  end
  task automatic tick(input logic v, input logic [N-1:0] d, output bit acc);
    @(negedge clk);
    if (stall_arm && bus.win_valid) begin stall_left = 5; stall_arm = 0; end
    bus.win_ready = (stall_left > 0) ? 1'b0 : rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (stall_left > 0) stall_left--;
    bus.in_valid = v;
    bus.in_data  = d;
    #1 acc = v && bus.in_ready;
  endtask
  task automatic send_pix(input logic [N-1:0] d);
    bit acc;
    int n = 0;
    if (gaps && $urandom_range(0, 1) == 1) tick(1'b0, '0, acc);
    do begin
      tick(1'b1, d, acc);
      n++;
      if (n > 200) begin $display("FAIL stuck: in_ready=0 required 1 within 200 cycles"); $fatal(1, "input stalled"); end
    end while (!acc);
  endtask
  task automatic send_frame(input logic [N-1:0] p [W*H], input bit push, input int count);
    for (int i = 0; i < count; i++) begin
      if (push && ((i / W) % 2 == 1) && ((i % W) % 2 == 1))
        q.push_back({p[i-W-1], p[i-W], p[i-1], p[i], 1'(i == W*H-1)});
      send_pix(p[i]);
    end
  endtask
  task automatic idle();
    bit acc;
    tick(1'b0, '0, acc);
  endtask
  task automatic check_reset();
    win_t o;
    o = {bus.win_tl, bus.win_tr, bus.win_bl, bus.win_br, bus.win_last};
    vectors++;
    if (bus.win_valid !== 1'b0 || o !== '0 || bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL reset: win_valid=%b outs=%h in_ready=%b required 0,0,1", bus.win_valid, o, bus.in_ready);
    end
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin idle(); n++; end
    repeat (3) idle();
    vectors++;
    if (q.size() != 0) begin fails++; $display("FAIL drain: %0d windows outstanding, required 0", q.size()); end
  endtask
  logic [N-1:0] f [W*H];
  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.win_ready = 1'b1;
    #12 check_reset();
    @(negedge clk) rst_n = 1'b1;
    // frame 0..15 with ready held high, hand-computed windows
    q.push_back({16'd0, 16'd1, 16'd4, 16'd5, 1'b0});
    q.push_back({16'd2, 16'd3, 16'd6, 16'd7, 1'b0});
    q.push_back({16'd8, 16'd9, 16'd12, 16'd13, 1'b0});
    q.push_back({16'd10, 16'd11, 16'd14, 16'd15, 1'b1});
    for (int i = 0; i < 16; i++) f[i] = N'(i);
    send_frame(f, 1'b0, 16);
    drain();
    // same stream with a 5-cycle stall after the first window
    stall_arm = 1;
    send_frame(f, 1'b1, 16);
    drain();
    // two frames back to back: 0..15 then 100..115
    q.push_back({16'd0, 16'd1, 16'd4, 16'd5, 1'b0});
    q.push_back({16'd2, 16'd3, 16'd6, 16'd7, 1'b0});
    q.push_back({16'd8, 16'd9, 16'd12, 16'd13, 1'b0});
    q.push_back({16'd10, 16'd11, 16'd14, 16'd15, 1'b1});
    q.push_back({16'd100, 16'd101, 16'd104, 16'd105, 1'b0});
    q.push_back({16'd102, 16'd103, 16'd106, 16'd107, 1'b0});
    q.push_back({16'd108, 16'd109, 16'd112, 16'd113, 1'b0});
    q.push_back({16'd110, 16'd111, 16'd114, 16'd115, 1'b1});
    send_frame(f, 1'b0, 16);
    for (int i = 0; i < 16; i++) f[i] = N'(100 + i);
    send_frame(f, 1'b0, 16);
    drain();
    // random input gaps and random downstream readiness
    gaps = 1; rdy_rand = 1;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++) f[i] = N'($urandom);
      send_frame(f, 1'b1, 16);
    end
    gaps = 0; rdy_rand = 0;
    drain();
    // reset after pixel 6 of a frame, then a fresh frame
    for (int i = 0; i < 16; i++) f[i] = N'(i);
    send_frame(f, 1'b1, 7);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1 check_reset();
    repeat (2) @(negedge clk);
    #1 check_reset();
    @(negedge clk) rst_n = 1'b1;
    send_frame(f, 1'b1, 16);
    drain();
    // full-scale and zero alternating, bit-exact pass-through
    for (int i = 0; i < 16; i++) f[i] = (i % 2 == 0) ? 16'hFFFF : 16'h0000;
    send_frame(f, 1'b1, 16);
    for (int i = 0; i < 16; i++) f[i] = ((i / W) % 2 == 0) ? 16'h0000 : 16'hFFFF;
    send_frame(f, 1'b1, 16);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end
endmodule
